rsc_encoder: RTL and testbench

Parametrised recursive systematic convolutional (RSC) constituent encoder for the turbo/MAP decoding chain, with generator polynomials and memory depth set by parameter. Accepts a framed bit stream over a valid/ready handshake and emits one systematic/parity pair per bit through a registered output. It can optionally append trellis-termination tail bits so every frame ends in the all-zero state that the MAP decoder expects. Sits between the frame source/interleaver and the puncturer/channel model.

---
 rtl/rsc_pkg.sv | 21 ++
 rtl/rsc_trellis_step.sv | 47 ++++
 rtl/rsc_encoder.sv | 151 +++++++++++++++
 tb/tb_rsc_encoder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsc_pkg.sv
// Shared types, default polynomials and the masked-XOR helper for the RSC
// encoder and any trellis-table consumers.
package rsc_pkg;

    typedef enum logic {
        ST_DATA = 1'b0,
        ST_TAIL = 1'b1
    } rsc_state_e;

    localparam int         RSC_MEM_MAX     = 8;
    localparam int         RSC_MEM_DEFAULT = 3;
    localparam logic [3:0] RSC_FB_DEFAULT  = 4'b1101;
    localparam logic [3:0] RSC_FF_DEFAULT  = 4'b1011;

    // Bit i of taps carries the tap value for the D^i coefficient.
    function automatic logic masked_xor(input logic [RSC_MEM_MAX:0] poly,
                                        input logic [RSC_MEM_MAX:0] taps);
        return ^(poly & taps);
    endfunction

endpackage

// File: rtl/rsc_trellis_step.sv
// One combinational trellis step: (u, state, tail) -> (sys, par, next_state).
// In tail mode the input is forced to the feedback value, so a = 0.
module rsc_trellis_step
    import rsc_pkg::*;
#(
    parameter int           MEM     = RSC_MEM_DEFAULT,
    parameter logic [MEM:0] FB_POLY = RSC_FB_DEFAULT,
    parameter logic [MEM:0] FF_POLY = RSC_FF_DEFAULT
) (
    input  logic           u_i,
    input  logic [MEM-1:0] state_i,
    input  logic           tail_i,
    output logic           sys_o,
    output logic           par_o,
    output logic [MEM-1:0] next_state_o
);

    logic [RSC_MEM_MAX:0] fb_ext;
    logic [RSC_MEM_MAX:0] ff_ext;
    logic [RSC_MEM_MAX:0] taps;
    logic [RSC_MEM_MAX:0] taps_par;
    logic                 fb;
    logic                 a;

    always_comb begin
        fb_ext = '0;
        ff_ext = '0;
        taps   = '0;
        for (int i = 0; i <= MEM; i++) begin
            fb_ext[i] = FB_POLY[i];
            ff_ext[i] = FF_POLY[i];
        end
        // s1 lives in the MSB of the state vector
        for (int i = 1; i <= MEM; i++) begin
            taps[i] = state_i[MEM-i];
        end
        fb          = masked_xor(fb_ext, taps);
        sys_o       = tail_i ? fb : u_i;
        a           = sys_o ^ fb;
        taps_par    = taps;
        taps_par[0] = a;
        par_o       = masked_xor(ff_ext, taps_par);
    end

    assign next_state_o = {a, state_i[MEM-1:1]};

endmodule

// File: rtl/rsc_encoder.sv
// RSC constituent encoder: valid/ready bit input, registered (sys, par) output.
// Define RSC_TAIL_EN to append MEM termination beats so each frame ends in state 0.
//
// state   | meaning
// ST_DATA | accepting information bits, one per free output slot
// ST_TAIL | emitting MEM termination beats, input stalled
module rsc_encoder
    import rsc_pkg::*;
#(
    parameter int           MEM     = RSC_MEM_DEFAULT,
    parameter logic [MEM:0] FB_POLY = RSC_FB_DEFAULT,
    parameter logic [MEM:0] FF_POLY = RSC_FF_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic           s_bit,
    input  logic           s_last,
    output logic           m_valid,
    input  logic           m_ready,
    output logic           m_sys,
    output logic           m_par,
    output logic           m_tail,
    output logic           m_last,
    output logic [MEM-1:0] state
);

`ifdef RSC_TAIL_EN
    localparam int CNT_W = $clog2(MEM + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    rsc_state_e     fsm_q, fsm_d;
    logic [MEM-1:0] state_q, state_d;
    logic           m_valid_q, m_valid_d;
    logic           sys_q, sys_d;
    logic           par_q, par_d;
    logic           tail_q, tail_d;
    logic           last_q, last_d;

    logic           out_free;
    logic           step_sys;
    logic           step_par;
    logic [MEM-1:0] step_next;

    assign out_free = !m_valid_q || m_ready;
    assign s_ready  = (fsm_q == ST_DATA) && out_free && !rst;

    rsc_trellis_step #(
        .MEM     (MEM),
        .FB_POLY (FB_POLY),
        .FF_POLY (FF_POLY)
    ) u_step (
        .u_i          (s_bit),
        .state_i      (state_q),
        .tail_i       (fsm_q == ST_TAIL),
        .sys_o        (step_sys),
        .par_o        (step_par),
        .next_state_o (step_next)
    );

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        m_valid_d = m_valid_q && !m_ready;
        sys_d     = sys_q;
        par_d     = par_q;
        tail_d    = tail_q;
        last_d    = last_q;
`ifdef RSC_TAIL_EN
        cnt_d     = cnt_q;
`endif
        case (fsm_q)
            ST_DATA: begin
                if (s_valid && s_ready) begin
                    m_valid_d = 1'b1;
                    sys_d     = step_sys;
                    par_d     = step_par;
                    tail_d    = 1'b0;
                    state_d   = step_next;
`ifdef RSC_TAIL_EN
                    last_d    = 1'b0;
                    if (s_last) begin
                        fsm_d = ST_TAIL;
                        cnt_d = CNT_W'(MEM);
                    end
`else
                    // Unterminated frames: restart the next frame from zero
                    last_d    = s_last;
                    if (s_last) begin
                        state_d = '0;
                    end
`endif
                end
            end
            default: begin
`ifdef RSC_TAIL_EN
                if (out_free) begin
                    m_valid_d = 1'b1;
                    sys_d     = step_sys;
                    par_d     = step_par;
                    tail_d    = 1'b1;
                    state_d   = step_next;
                    last_d    = (cnt_q == CNT_W'(1));
                    cnt_d     = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        fsm_d = ST_DATA;
                    end
                end
`else
                fsm_d = ST_DATA;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q     <= ST_DATA;
            state_q   <= '0;
            m_valid_q <= 1'b0;
            sys_q     <= 1'b0;
            par_q     <= 1'b0;
            tail_q    <= 1'b0;
            last_q    <= 1'b0;
`ifdef RSC_TAIL_EN
            cnt_q     <= '0;
`endif
        end else begin
            fsm_q     <= fsm_d;
            state_q   <= state_d;
            m_valid_q <= m_valid_d;
            sys_q     <= sys_d;
            par_q     <= par_d;
            tail_q    <= tail_d;
            last_q    <= last_d;
`ifdef RSC_TAIL_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign m_valid = m_valid_q;
    assign m_sys   = sys_q;
    assign m_par   = par_q;
    assign m_tail  = tail_q;
    assign m_last  = last_q;
    assign state   = state_q;

endmodule

// File: tb/tb_rsc_encoder.sv
// Scoreboard bench for rsc_encoder: default instance (MEM=3) and a MEM=4 instance.
// Expected beats come from a behavioural model and are queued on each accepted input.
`timescale 1ns/1ps
module tb_rsc_encoder;

`ifdef RSC_TAIL_EN
    localparam bit TAIL_EN = 1'b1;
`else
    localparam bit TAIL_EN = 1'b0;
`endif
    localparam int M0 = 3;
    localparam int M1 = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] s_valid = '0;
    logic [1:0] s_bit   = '0;
    logic [1:0] s_last  = '0;
    logic [1:0] m_ready = '0;
    wire  [1:0] s_ready, m_valid, m_sys, m_par, m_tail, m_last;
    wire  [M0-1:0] state0;
    wire  [M1-1:0] state1;

    int checks = 0;
    int errors = 0;
    bit rnd_mode = 1'b0;
    bit gaps     = 1'b0;
    bit log_en   = 1'b0;

    int         mem_p [2] = '{M0, M1};
    logic [8:0] fb_p  [2] = '{9'b0_0000_1101, 9'b0_0001_0011};
    logic [8:0] ff_p  [2] = '{9'b0_0000_1011, 9'b0_0001_1101};
    logic [7:0] mst   [2] = '{8'd0, 8'd0};

    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic [3:0] obs_log[$];
    logic [3:0] exp_tab[$];
    bit         hold_v [2] = '{1'b0, 1'b0};
    logic [3:0] hold_b [2] = '{4'd0, 4'd0};

    always #5 clk = ~clk;

    rsc_encoder #(.MEM(M0), .FB_POLY(4'b1101), .FF_POLY(4'b1011)) dut0 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_bit(s_bit[0]), .s_last(s_last[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_sys(m_sys[0]), .m_par(m_par[0]),
        .m_tail(m_tail[0]), .m_last(m_last[0]), .state(state0)
    );

    rsc_encoder #(.MEM(M1), .FB_POLY(5'b10011), .FF_POLY(5'b11101)) dut1 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_bit(s_bit[1]), .s_last(s_last[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_sys(m_sys[1]), .m_par(m_par[1]),
        .m_tail(m_tail[1]), .m_last(m_last[1]), .state(state1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic mx(input logic [8:0] poly, input logic [7:0] st, input int mem);
        logic r;
        r = 1'b0;
        for (int i = 1; i <= mem; i++) r ^= poly[i] & st[mem-i];
        return r;
    endfunction

    function automatic void model_step(input int d, input logic [7:0] st, input logic u_in,
                                       input logic tail, output logic sys, output logic par,
                                       output logic [7:0] nxt);
        int   mem;
        logic fb, a;
        mem = mem_p[d];
        fb  = mx(fb_p[d], st, mem);
        sys = tail ? fb : u_in;
        a   = sys ^ fb;
        par = (ff_p[d][0] & a) ^ mx(ff_p[d], st, mem);
        nxt = (st >> 1) | (8'(a) << (mem - 1));
    endfunction

    task automatic push_exp(input int d, input logic [3:0] v);
        if (d == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    task automatic model_accept(input int d, input logic u, input logic l);
        logic [7:0] st, nxt;
        logic       sys, par;
        st = mst[d];
        model_step(d, st, u, 1'b0, sys, par, nxt);
        st = nxt;
        if (TAIL_EN && l) begin
            push_exp(d, {sys, par, 2'b00});
            for (int k = 0; k < mem_p[d]; k++) begin
                model_step(d, st, 1'b0, 1'b1, sys, par, nxt);
                st = nxt;
                push_exp(d, {sys, par, 1'b1, (k == mem_p[d] - 1)});
            end
        end else begin
            push_exp(d, {sys, par, 1'b0, l});
            if (l) st = '0;
        end
        mst[d] = st;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            mst[0] = '0;
            mst[1] = '0;
            hold_v[0] = 1'b0;
            hold_v[1] = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                logic [3:0] obs, expv;
                int         qs;
                obs = {m_sys[d], m_par[d], m_tail[d], m_last[d]};
                if (hold_v[d]) begin
                    check_eq($sformatf("stall_valid%0d", d), m_valid[d], 1);
                    check_eq($sformatf("stall_hold%0d", d), obs, hold_b[d]);
                end
                hold_v[d] = m_valid[d] && !m_ready[d];
                hold_b[d] = obs;
                if (m_valid[d] && m_ready[d]) begin
                    qs = (d == 0) ? q0.size() : q1.size();
                    if (qs == 0) begin
                        check_eq($sformatf("extra_beat%0d", d), qs, 1);
                    end else begin
                        expv = (d == 0) ? q0.pop_front() : q1.pop_front();
                        check_eq($sformatf("beat_dut%0d", d), obs, expv);
                    end
                    if (d == 0 && log_en) obs_log.push_back(obs);
                end
                if (s_valid[d] && s_ready[d]) model_accept(d, s_bit[d], s_last[d]);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        m_ready = rnd_mode ? 2'($urandom_range(0, 3)) : 2'b11;
    end

    task automatic send_beat(input int d, input logic b, input logic l);
        bit acc;
        int n;
        if (gaps && $urandom_range(0, 3) == 0) begin
            s_valid[d] = 1'b0;
            @(posedge clk);
            #1;
        end
        s_valid[d] = 1'b1;
        s_bit[d]   = b;
        s_last[d]  = l;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = s_ready[d];
            @(posedge clk);
            #1;
            n++;
        end
        s_valid[d] = 1'b0;
        s_bit[d]   = 1'($urandom);
        s_last[d]  = 1'($urandom);
        if (!acc) check_eq("accept_timeout", acc, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0)
            check_eq("drain_timeout", q0.size() + q1.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_m_valid", m_valid[0], 0);
        check_eq("rst_m_last", m_last[0], 0);
        check_eq("rst_state", state0, 0);
        check_eq("rst_s_ready", s_ready[0], 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("idle_s_ready", s_ready[0], 1);
        @(posedge clk);
        #1;

        // Directed frame 1,0,0,0 with m_ready held high
        log_en = 1'b1;
        send_beat(0, 1'b1, 1'b0);
        send_beat(0, 1'b0, 1'b0);
        send_beat(0, 1'b0, 1'b0);
        send_beat(0, 1'b0, 1'b1);
        check_eq("state_after_data", state0, TAIL_EN ? 3'b110 : 3'b000);
        wait_idle();
        log_en = 1'b0;
        if (TAIL_EN) exp_tab = '{4'b1100, 4'b0100, 4'b0100, 4'b0100, 4'b1110, 4'b0110, 4'b1111};
        else         exp_tab = '{4'b1100, 4'b0100, 4'b0100, 4'b0101};
        check_eq("dir_len", obs_log.size(), exp_tab.size());
        for (int i = 0; i < exp_tab.size() && i < obs_log.size(); i++)
            check_eq($sformatf("dir_beat%0d", i), obs_log[i], exp_tab[i]);
        check_eq("dir_final_state", state0, 0);

        // Back-to-back one-bit frames
        s_valid[0] = 1'b1;
        s_last[0]  = 1'b1;
        s_bit[0]   = 1'($urandom);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check_eq("rdy_pattern", s_ready[0], TAIL_EN ? (k % (M0 + 1) == 0) : 1);
            @(posedge clk);
            #1 s_bit[0] = 1'($urandom);
        end
        s_valid[0] = 1'b0;
        wait_idle();

        // Reset during the second tail beat
        send_beat(0, 1'b1, 1'b0);
        send_beat(0, 1'b1, 1'b0);
        send_beat(0, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_valid", m_valid[0], 0);
        check_eq("rst_mid_state", state0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 12; i++) send_beat(0, 1'($urandom), i == 11);
        wait_idle();
        check_eq("post_rst_state", state0, 0);

        // Random bits with random backpressure and input gaps
        rnd_mode = 1'b1;
        gaps     = 1'b1;
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < 100; i++) send_beat(0, 1'($urandom), i == 99);
        end
        wait_idle();
        check_eq("rand_final_state", state0, 0);

        // MEM=4 instance
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 200; i++) send_beat(1, 1'($urandom), i == 199);
            wait_idle();
            check_eq("m4_final_state", state1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
